pipeline_hazard_ctrl: RTL

- Parametrised hazard and forwarding controller for the in-order pipelined CPU.
- Keeps a per-stage scoreboard of in-flight writers (stage 0 = EX up to stage STAGES-1 = WB).
- For the instruction in ID, it decides whether to issue, stall or squash. It produces registered forward-selects for EX, and kills younger stages when a branch is taken.
- Adds load-use stalls, configurable depth and result-ready points, and saturating stall/flush counters.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 23 ++
 rtl/pipeline_hazard_match.sv | 40 ++++
 rtl/pipeline_hazard_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the hazard/forwarding controller: the scoreboard entry,
// the forward-select width helper and the register-file select code.
package pipeline_hazard_ctrl_pkg;

   // Wide enough for any supported register-number width; narrower numbers are zero-extended.
   localparam int DEST_FIELD_WIDTH = 8;

   localparam int FWD_REGFILE = 0;

   typedef struct packed {
      logic                        valid;
      logic                        reg_write;
      logic                        is_load;
      logic [DEST_FIELD_WIDTH-1:0] dest;
   } sb_entry_t;

   localparam sb_entry_t SB_BUBBLE = '0;

   function automatic int sel_width(input int stages);
      return $clog2(stages + 1);
   endfunction

endpackage

// File: rtl/pipeline_hazard_match.sv
// Finds the youngest in-flight writer of one ID source register and reports
// whether its result will be available by the time the consumer reaches EX.
module hazard_match
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter  int STAGES        = 3,
   parameter  int REG_NUM_WIDTH = 5,
   parameter  int ALU_READY     = 1,
   parameter  int LOAD_READY    = 2,
   localparam int SEL_WIDTH     = sel_width(STAGES)
) (
   input  sb_entry_t                entries [STAGES],
   input  logic [REG_NUM_WIDTH-1:0] src,
   input  logic                     uses,
   output logic [SEL_WIDTH-1:0]     idx,
   output logic                     hit,
   output logic                     ready
);

   logic [DEST_FIELD_WIDTH-1:0] src_ext;

   assign src_ext = DEST_FIELD_WIDTH'(src);

   // NOTE: every output gets a default before the loop so no latch is inferred.
   always_comb begin
      hit   = 1'b0;
      idx   = '0;
      ready = 1'b0;
      // Oldest first, so the youngest match is the last one to overwrite.
      for (int i = STAGES - 1; i >= 0; i--) begin
         if (uses && entries[i].valid && entries[i].reg_write &&
             entries[i].dest != '0 && entries[i].dest == src_ext) begin
            hit   = 1'b1;
            idx   = SEL_WIDTH'(i);
            ready = (i + 1) >= (entries[i].is_load ? LOAD_READY : ALU_READY);
         end
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and forwarding controller: tracks in-flight writers per stage, stalls
// load-use hazards, squashes on taken branches and registers EX forward-selects.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter  int STAGES        = 3,
   parameter  int REG_NUM_WIDTH = 5,
   parameter  int ALU_READY     = 1,
   parameter  int LOAD_READY    = 2,
   parameter  int BR_STAGE      = 1,
   parameter  int CNT_WIDTH     = 32,
   localparam int SEL_WIDTH     = sel_width(STAGES)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     idValid,
   input  logic [REG_NUM_WIDTH-1:0] idRs,
   input  logic [REG_NUM_WIDTH-1:0] idRt,
   input  logic                     idUsesRs,
   input  logic                     idUsesRt,
   input  logic                     idRegWrite,
   input  logic [REG_NUM_WIDTH-1:0] idDest,
   input  logic                     idIsLoad,
   input  logic                     brTaken,
   output logic                     pcHold,
   output logic                     ifidHold,
   output logic                     ifidFlush,
   output logic                     idexBubble,
   output logic [STAGES-1:0]        stageKill,
   output logic [SEL_WIDTH-1:0]     fwdSelA,
   output logic [SEL_WIDTH-1:0]     fwdSelB,
   output logic [CNT_WIDTH-1:0]     stallCount,
   output logic [CNT_WIDTH-1:0]     flushCount
);

   if (ALU_READY > LOAD_READY || LOAD_READY > STAGES || BR_STAGE >= STAGES ||
       REG_NUM_WIDTH > DEST_FIELD_WIDTH) begin : g_param_check
      $error("pipeline_hazard_ctrl: illegal parameter combination");
   end

   localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(STAGES - 1);
   localparam logic [SEL_WIDTH-1:0] SEL_RF   = SEL_WIDTH'(FWD_REGFILE);

   sb_entry_t            entries [STAGES];
   sb_entry_t            id_entry;
   logic [SEL_WIDTH-1:0] idx_a, idx_b;
   logic                 hit_a, hit_b, ready_a, ready_b;
   logic                 stall, issue;
   logic [SEL_WIDTH-1:0] sel_a_next, sel_b_next;

   hazard_match #(
      .STAGES       (STAGES),
      .REG_NUM_WIDTH(REG_NUM_WIDTH),
      .ALU_READY    (ALU_READY),
      .LOAD_READY   (LOAD_READY)
   ) u_match_a (
      .entries(entries),
      .src    (idRs),
      .uses   (idValid & idUsesRs),
      .idx    (idx_a),
      .hit    (hit_a),
      .ready  (ready_a)
   );

   hazard_match #(
      .STAGES       (STAGES),
      .REG_NUM_WIDTH(REG_NUM_WIDTH),
      .ALU_READY    (ALU_READY),
      .LOAD_READY   (LOAD_READY)
   ) u_match_b (
      .entries(entries),
      .src    (idRt),
      .uses   (idValid & idUsesRt),
      .idx    (idx_b),
      .hit    (hit_b),
      .ready  (ready_b)
   );

   always_comb begin
      id_entry           = SB_BUBBLE;
      id_entry.valid     = idValid;
      id_entry.reg_write = idRegWrite;
      id_entry.is_load   = idIsLoad;
      id_entry.dest      = DEST_FIELD_WIDTH'(idDest);
   end

   // A taken branch squashes ID, so it masks any hazard the ID instruction has.
   always_comb begin
      stall = idValid && !brTaken && ((hit_a && !ready_a) || (hit_b && !ready_b));
      issue = !stall && !brTaken;
      // A match in the last stage has retired into the register file by EX time.
      sel_a_next = (issue && hit_a && idx_a != LAST_IDX) ? idx_a + SEL_WIDTH'(1) : SEL_RF;
      sel_b_next = (issue && hit_b && idx_b != LAST_IDX) ? idx_b + SEL_WIDTH'(1) : SEL_RF;
   end

   always_comb begin
      stageKill = '0;
      for (int k = 0; k < STAGES; k++) begin
         stageKill[k] = brTaken && (k < BR_STAGE);
      end
   end

   assign pcHold     = stall;
   assign ifidHold   = stall;
   assign ifidFlush  = brTaken;
   assign idexBubble = stall | brTaken;

   // NOTE: state is updated with non-blocking assignments so every entry shifts from its pre-edge neighbour.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) begin
            entries[i] <= SB_BUBBLE;
         end
         fwdSelA    <= SEL_RF;
         fwdSelB    <= SEL_RF;
         stallCount <= '0;
         flushCount <= '0;
      end else begin
         entries[0] <= (stall || brTaken) ? SB_BUBBLE : id_entry;
         for (int i = 1; i < STAGES; i++) begin
            entries[i] <= (brTaken && i <= BR_STAGE) ? SB_BUBBLE : entries[i-1];
         end
         fwdSelA <= sel_a_next;
         fwdSelB <= sel_b_next;
         if (stall && stallCount != '1) begin
            stallCount <= stallCount + CNT_WIDTH'(1);
         end
         if (brTaken && flushCount != '1) begin
            flushCount <= flushCount + CNT_WIDTH'(1);
         end
      end
   end

endmodule
